gate_op_sequencer: RTL
======================

Name: gate_op_sequencer

Overview:
- Upstream stage of the 4-bit gate-result multiplexor.
- Buffers operation commands (opcode plus two 4-bit operands) in a small FIFO and issues them one at a time.
- For each issued command it drives the operands to the AND/OR/NAND/XOR gate stage and a one-hot selector to the multiplexor.
- Each issued command is held for a programmable number of cycles, then the next one is issued.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2
HOLD_CYCLES, 2, cycles each issued command is held valid; >= 1
DATA_W, 4, operand width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= not full)
cmd_op  input  2  00 AND, 01 OR, 10 NAND, 11 XOR
cmd_a  input  DATA_W  operand A
cmd_b  input  DATA_W  operand B
seq_a  output  DATA_W  issued operand A to gate stage
seq_b  output  DATA_W  issued operand B to gate stage
seq_selector  output  4  one-hot mux select
seq_valid  output  1  seq_* outputs carry an active command
seq_done  output  1  one-cycle pulse on the last hold cycle of a command
seq_busy  output  1  FSM not IDLE or FIFO non-empty
fifo_count  output  clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: cmd_ready=1; seq_a=0, seq_b=0, seq_selector=4'b0000, seq_valid=0, seq_done=0, seq_busy=0, fifo_count=0. FIFO pointers are cleared.
- Reset mid-operation: the in-flight command and all queued commands are discarded. No seq_done pulse is generated.
- Push: a command is written when cmd_valid && cmd_ready. cmd_ready = (fifo_count != FIFO_DEPTH), registered-state based.
  - Push is refused when the FIFO is full, even if a pop occurs in the same cycle.
  - There is no bypass: a command pushed into an empty FIFO becomes poppable the next cycle.
- Opcode decode:
  - 00 -> 0001
  - 01 -> 0010
  - 10 -> 0100
  - 11 -> 1000
  - seq_selector is never multi-hot. It is 0000 whenever seq_valid=0.
- FSM states: IDLE, HOLD.
- IDLE:
  - If the FIFO is non-empty: pop; register op/a/b onto seq_*; seq_valid=1; hold counter = HOLD_CYCLES-1; go to HOLD.
  - Otherwise stay in IDLE with seq_valid=0 and seq_selector=0000. seq_a/seq_b keep their last values.
- HOLD:
  - While the counter != 0: decrement; outputs stable.
  - When the counter == 0: seq_done=1 for this cycle.
    - If the FIFO is non-empty, pop the next command so it appears the following cycle (back-to-back, no bubble) and stay in HOLD.
    - Otherwise go to IDLE; seq_valid drops the following cycle.
- Latency: command pushed in cycle t into an empty FIFO with the FSM in IDLE -> popped at t+1 -> seq_valid=1 at t+2.
  - seq_done is asserted in the HOLD_CYCLES-th cycle of seq_valid.
- Simultaneous push and pop: fifo_count is unchanged. Pointer wrap at FIFO_DEPTH is modulo.
- HOLD_CYCLES=1: every valid cycle also asserts seq_done.
- fifo_count counts only queued entries; the issued command is not included.

Optional Feature:
- Macro: AUTO_SCAN_EN.
- Defined:
  - Adds input port scan_en (1 bit).
  - When scan_en=1, the FSM is in IDLE and the FIFO is empty, the block self-issues a scan using the last seq_a/seq_b. The selector steps 0001 -> 0010 -> 0100 -> 1000 -> 0001, each held HOLD_CYCLES, with seq_valid=1 and seq_done=0 throughout.
  - A queued command has priority: the scan stops at the end of the current step and the command issues next.
  - Deasserting scan_en ends the scan at the end of the current step.
- Undefined: no scan_en port; behaviour exactly as above.

Test Plan:
1. Reset, then push op=00 a=4'hC b=4'hA (HOLD_CYCLES=2) -> two cycles later seq_selector=0001, seq_a=C, seq_b=A, seq_valid=1 for 2 cycles; seq_done on the 2nd; then seq_valid=0, selector=0000.
2. Push ops 01, 10, 11 on consecutive cycles -> selectors 0010, 0100, 1000 each held 2 cycles, back-to-back with no bubble; three seq_done pulses; seq_busy drops after the last.
3. Hold the FSM busy and push 5 commands with FIFO_DEPTH=4 -> cmd_ready=0 once fifo_count=4; the 5th is stalled until a pop, then accepted; all 5 issue in order.
4. Push while full in the same cycle as a pop -> push refused, fifo_count goes 4 -> 3; the pushed command is accepted the next cycle.
5. Assert reset during HOLD with 2 entries queued -> next cycle all outputs at reset values, fifo_count=0, no seq_done; subsequent pushes operate normally.
6. (AUTO_SCAN_EN) After command a=3 b=5 completes, scan_en=1 -> selector cycles 0001/0010/0100/1000, 2 cycles each, seq_a=3, seq_b=5, seq_done=0; pushing op=11 ends the scan at the current step boundary, then 1000 issues with seq_done.

Source files
------------

// File: rtl/gate_op_sequencer.sv
// rtl/gate_op_sequencer.sv - command FIFO and hold sequencer feeding the gate-result multiplexor
//
// Purpose:
//   Queues gate commands (opcode + operands A/B) and issues them one at a
//   time. Each issued command drives its operands and a one-hot selector for
//   HOLD_CYCLES cycles. seq_done pulses on the last of those cycles.
//   Back-to-back commands issue without a bubble.
//
// Optional feature (macro AUTO_SCAN_EN):
//   Adds input scan_en. While the block is idle with an empty FIFO, it steps
//   the selector 0001->0010->0100->1000 using the last operands, with no
//   seq_done. A queued command or scan_en low ends the scan at a step boundary.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b    opcode (00 AND, 01 OR, 10 NAND, 11 XOR) and operands
//   scan_en                 auto-scan request (AUTO_SCAN_EN builds only)
//   seq_a, seq_b            operands of the issued command
//   seq_selector            one-hot mux select, 0000 when not valid
//   seq_valid, seq_done     issued command active / last hold cycle
//   seq_busy                sequencer active or commands queued
//   fifo_count              queued entries, not counting the issued command

module gate_op_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int DATA_W      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [1:0]                    cmd_op,
   input  logic [DATA_W-1:0]             cmd_a,
   input  logic [DATA_W-1:0]             cmd_b,
`ifdef AUTO_SCAN_EN
   input  logic                          scan_en,
`endif
   output logic [DATA_W-1:0]             seq_a,
   output logic [DATA_W-1:0]             seq_b,
   output logic [3:0]                    seq_selector,
   output logic                          seq_valid,
   output logic                          seq_done,
   output logic                          seq_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 2 + 2 * DATA_W;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   state_t        state;
   logic [HW-1:0] hold_cnt;

   logic          push;
   logic          pop;
   logic          step_end;
   logic [EW-1:0] head;

   function automatic logic [3:0] decode(input logic [1:0] op);
      logic [3:0] sel;
      sel = 4'b0000;
      case (op)
         2'b00:   sel = 4'b0001;
         2'b01:   sel = 4'b0010;
         2'b10:   sel = 4'b0100;
         default: sel = 4'b1000;
      endcase
      return sel;
   endfunction

   // Ready depends only on registered occupancy, so a full FIFO refuses a
   // push even in a cycle where it also pops.
   assign cmd_ready  = (count != CW'(FIFO_DEPTH));
   assign push       = cmd_valid && cmd_ready;
   // Last cycle of the current hold (or scan step).
   assign step_end   = (state != IDLE) && (hold_cnt == '0);
   // Popping at step_end loads the next command for the following cycle,
   // which gives back-to-back issue without a bubble.
   assign pop        = (count != '0) && ((state == IDLE) || step_end);
   assign head       = mem[rd_ptr];
   assign seq_busy   = (state != IDLE) || (count != '0);
   assign fifo_count = count;

   // FIFO storage needs no reset: entries are only read behind the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         state        <= IDLE;
         hold_cnt     <= '0;
         seq_a        <= '0;
         seq_b        <= '0;
         seq_selector <= 4'b0000;
         seq_valid    <= 1'b0;
         seq_done     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (pop) begin
            state        <= HOLD;
            hold_cnt     <= HOLD_RELOAD;
            seq_a        <= head[2*DATA_W-1 -: DATA_W];
            seq_b        <= head[DATA_W-1:0];
            seq_selector <= decode(head[EW-1 -: 2]);
            seq_valid    <= 1'b1;
            seq_done     <= (HOLD_CYCLES == 1);
         end else begin
            case (state)
               IDLE: begin
`ifdef AUTO_SCAN_EN
                  // pop has priority, so reaching here means the FIFO is empty.
                  if (scan_en) begin
                     state        <= SCAN;
                     hold_cnt     <= HOLD_RELOAD;
                     seq_selector <= 4'b0001;
                     seq_valid    <= 1'b1;
                     seq_done     <= 1'b0;
                  end
`endif
               end
               HOLD, SCAN: begin
                  if (hold_cnt != '0) begin
                     hold_cnt <= hold_cnt - HW'(1);
                     // Announce the final hold cycle of a real command.
                     seq_done <= (state == HOLD) && (hold_cnt == HW'(1));
                  end else begin
`ifdef AUTO_SCAN_EN
                     if ((state == SCAN) && scan_en) begin
                        hold_cnt     <= HOLD_RELOAD;
                        seq_selector <= {seq_selector[2:0], seq_selector[3]};
                        seq_done     <= 1'b0;
                     end else begin
                        state        <= IDLE;
                        seq_selector <= 4'b0000;
                        seq_valid    <= 1'b0;
                        seq_done     <= 1'b0;
                     end
`else
                     state        <= IDLE;
                     seq_selector <= 4'b0000;
                     seq_valid    <= 1'b0;
                     seq_done     <= 1'b0;
`endif
                  end
               end
               default: begin
                  state        <= IDLE;
                  seq_selector <= 4'b0000;
                  seq_valid    <= 1'b0;
                  seq_done     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
